// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch prediction controller.
// Holds the FSM state encoding, the in-flight prediction record and the PC increment.
package bpu_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = PC_W'(32'd4);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_FLUSH  = 2'd2
  } bpu_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] next_pc;
    logic            hit;
  } pred_entry_t;

  // Saturating increment for the 32-bit statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Fetch / BTB / execute signal bundle of the branch prediction controller.
// Optional statistics outputs exist only when BPU_STATS_EN is defined.
interface branch_predict_ctrl_if;
  import bpu_pkg::*;

  logic            if_valid;
  logic [PC_W-1:0] if_pc;
  logic            if_stall;
  logic            if_next_valid;
  logic [PC_W-1:0] if_next_pc;
  logic            btb_query;
  logic [PC_W-1:0] btb_pc_query;
  logic            btb_success;
  logic [PC_W-1:0] btb_predict;
  logic            btb_store;
  logic [PC_W-1:0] btb_pc_update;
  logic [PC_W-1:0] btb_next_pc;
  logic            btb_pred_result;
  logic            ex_valid;
  logic            ex_is_branch;
  logic [PC_W-1:0] ex_next_pc;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            err_underflow;
`ifdef BPU_STATS_EN
  logic [31:0]     stat_lookups;
  logic [31:0]     stat_hits;
  logic [31:0]     stat_mispred;
`endif

  modport master (
    input  if_valid, if_pc, btb_success, btb_predict, ex_valid, ex_is_branch, ex_next_pc,
    output if_stall, if_next_valid, if_next_pc, btb_query, btb_pc_query, btb_store,
           btb_pc_update, btb_next_pc, btb_pred_result, redirect, redirect_pc, err_underflow
`ifdef BPU_STATS_EN
    , output stat_lookups, stat_hits, stat_mispred
`endif
  );

  modport slave (
    output if_valid, if_pc, btb_success, btb_predict, ex_valid, ex_is_branch, ex_next_pc,
    input  if_stall, if_next_valid, if_next_pc, btb_query, btb_pc_query, btb_store,
           btb_pc_update, btb_next_pc, btb_pred_result, redirect, redirect_pc, err_underflow
`ifdef BPU_STATS_EN
    , input stat_lookups, stat_hits, stat_mispred
`endif
  );

endinterface

// File: rtl/pred_fifo.sv
// Synchronous FIFO of in-flight predictions; flush clears it and overrides a push.
// Pointers wrap naturally because DEPTH is a power of two.
module pred_fifo
  import bpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear_n,
  input  logic                     push,
  input  pred_entry_t              push_data,
  input  logic                     pop,
  input  logic                     flush,
  output pred_entry_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  pred_entry_t   mem_q [DEPTH];
  pred_entry_t   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == {(AW+1){1'b0}});
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state pointer, count and storage update.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// BTB query/store initiator: fetch-side lookup FSM, in-flight FIFO, execute-side resolve.
// Define BPU_STATS_EN to add saturating lookup/hit/mispredict counters.
module branch_predict_ctrl
  import bpu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 1
) (
  input logic                   clk,
  input logic                   clear_n,
  branch_predict_ctrl_if.master bus
);

  localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYC - 1);

  bpu_state_e      state_q, state_d;
  logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
  logic            btb_query_q, btb_query_d;
  logic [PC_W-1:0] btb_pc_query_q, btb_pc_query_d;
  logic            if_next_valid_q, if_next_valid_d;
  logic [PC_W-1:0] if_next_pc_q, if_next_pc_d;
  logic            btb_store_q, btb_store_d;
  logic [PC_W-1:0] btb_pc_update_q, btb_pc_update_d;
  logic [PC_W-1:0] btb_next_pc_q, btb_next_pc_d;
  logic            btb_pred_result_q, btb_pred_result_d;
  logic            redirect_q, redirect_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            err_underflow_q, err_underflow_d;

  pred_entry_t             head_s, push_data_s;
  logic                    fifo_full_s, fifo_empty_s;
  logic [$clog2(DEPTH):0]  fifo_count_s;
  logic                    unused_count_s;
  logic                    pop_s, mispredict_s, store_s, lookup_done_s, accept_s;
  logic [PC_W-1:0]         pred_pc_s;

  assign unused_count_s = ^fifo_count_s;

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .clear_n   (clear_n),
    .push      (lookup_done_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .flush     (mispredict_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Resolve decisions; a mispredict takes priority over any fetch-side activity.
  always_comb begin
    pop_s         = bus.ex_valid & ~fifo_empty_s;
    mispredict_s  = pop_s & (bus.ex_next_pc != head_s.next_pc);
    store_s       = pop_s & (bus.ex_is_branch | head_s.hit);
    lookup_done_s = (state_q == S_LOOKUP) & ~mispredict_s;
    accept_s      = (state_q == S_IDLE) & bus.if_valid & (~fifo_full_s | pop_s) & ~mispredict_s;
    pred_pc_s     = bus.btb_success ? bus.btb_predict : (btb_pc_query_q + PC_INC);
    push_data_s   = '{pc: btb_pc_query_q, next_pc: pred_pc_s, hit: bus.btb_success};
  end

  // FSM next state and next output register values.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (mispredict_s) begin
      state_d     = S_FLUSH;
      flush_cnt_d = FLUSH_LOAD;
    end else begin
      case (state_q)
        S_IDLE:   if (accept_s) state_d = S_LOOKUP; else state_d = S_IDLE;
        S_LOOKUP: state_d = S_IDLE;
        S_FLUSH: begin
          if (flush_cnt_q == {FCW{1'b0}}) state_d = S_IDLE;
          else flush_cnt_d = flush_cnt_q - FCW'(1'b1);
        end
        default:  state_d = S_IDLE;
      endcase
    end
    btb_query_d       = accept_s;
    btb_pc_query_d    = accept_s ? bus.if_pc : btb_pc_query_q;
    if_next_valid_d   = lookup_done_s;
    if_next_pc_d      = lookup_done_s ? pred_pc_s : if_next_pc_q;
    btb_store_d       = store_s;
    btb_pc_update_d   = store_s ? head_s.pc : btb_pc_update_q;
    btb_next_pc_d     = store_s ? bus.ex_next_pc : btb_next_pc_q;
    btb_pred_result_d = store_s ? mispredict_s : btb_pred_result_q;
    redirect_d        = mispredict_s;
    redirect_pc_d     = mispredict_s ? bus.ex_next_pc : redirect_pc_q;
    err_underflow_d   = err_underflow_q | (bus.ex_valid & fifo_empty_s);
  end

`ifdef BPU_STATS_EN
  logic [31:0] stat_lookups_q, stat_hits_q, stat_mispred_q;

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      stat_lookups_q <= 32'd0;
      stat_hits_q    <= 32'd0;
      stat_mispred_q <= 32'd0;
    end else begin
      if (lookup_done_s) stat_lookups_q <= sat_inc(stat_lookups_q);
      if (lookup_done_s & bus.btb_success) stat_hits_q <= sat_inc(stat_hits_q);
      if (mispredict_s) stat_mispred_q <= sat_inc(stat_mispred_q);
    end
  end

  assign bus.stat_lookups = stat_lookups_q;
  assign bus.stat_hits    = stat_hits_q;
  assign bus.stat_mispred = stat_mispred_q;
`endif

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q           <= S_IDLE;
      flush_cnt_q       <= {FCW{1'b0}};
      btb_query_q       <= 1'b0;
      btb_pc_query_q    <= {PC_W{1'b0}};
      if_next_valid_q   <= 1'b0;
      if_next_pc_q      <= {PC_W{1'b0}};
      btb_store_q       <= 1'b0;
      btb_pc_update_q   <= {PC_W{1'b0}};
      btb_next_pc_q     <= {PC_W{1'b0}};
      btb_pred_result_q <= 1'b0;
      redirect_q        <= 1'b0;
      redirect_pc_q     <= {PC_W{1'b0}};
      err_underflow_q   <= 1'b0;
    end else begin
      state_q           <= state_d;
      flush_cnt_q       <= flush_cnt_d;
      btb_query_q       <= btb_query_d;
      btb_pc_query_q    <= btb_pc_query_d;
      if_next_valid_q   <= if_next_valid_d;
      if_next_pc_q      <= if_next_pc_d;
      btb_store_q       <= btb_store_d;
      btb_pc_update_q   <= btb_pc_update_d;
      btb_next_pc_q     <= btb_next_pc_d;
      btb_pred_result_q <= btb_pred_result_d;
      redirect_q        <= redirect_d;
      redirect_pc_q     <= redirect_pc_d;
      err_underflow_q   <= err_underflow_d;
    end
  end

  // Stall is derived from registered state only, so fetch sees no input-to-output path.
  assign bus.if_stall        = (state_q != S_IDLE) | fifo_full_s;
  assign bus.btb_query       = btb_query_q;
  assign bus.btb_pc_query    = btb_pc_query_q;
  assign bus.if_next_valid   = if_next_valid_q;
  assign bus.if_next_pc      = if_next_pc_q;
  assign bus.btb_store       = btb_store_q;
  assign bus.btb_pc_update   = btb_pc_update_q;
  assign bus.btb_next_pc     = btb_next_pc_q;
  assign bus.btb_pred_result = btb_pred_result_q;
  assign bus.redirect        = redirect_q;
  assign bus.redirect_pc     = redirect_pc_q;
  assign bus.err_underflow   = err_underflow_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed scenarios plus a randomized
// transaction-level run against a queue model of in-flight predictions.
module tb_branch_predict_ctrl;
  import bpu_pkg::*;

  localparam int DEPTH     = 4;
  localparam int FLUSH_CYC = 1;

  logic clk     = 1'b0;
  logic clear_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  branch_predict_ctrl_if bus();

  branch_predict_ctrl #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] pred; logic hit; } model_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_valid = 1'b0; bus.if_pc = 32'd0; bus.btb_success = 1'b0; bus.btb_predict = 32'd0;
    bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_next_pc = 32'd0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic hit, input logic [31:0] tgt,
                       output logic q, output logic [31:0] qpc, output logic nv, output logic [31:0] npc);
    bus.if_valid = 1'b1; bus.if_pc = pc;
    step();
    q = bus.btb_query; qpc = bus.btb_pc_query;
    bus.if_valid = 1'b0; bus.btb_success = hit; bus.btb_predict = tgt;
    step();
    nv = bus.if_next_valid; npc = bus.if_next_pc;
    bus.btb_success = 1'b0; bus.btb_predict = 32'd0;
  endtask

  task automatic resolve(input logic br, input logic [31:0] nxt,
                         output logic st, output logic [31:0] pcu, output logic [31:0] nn,
                         output logic pr, output logic rd, output logic [31:0] rpc);
    bus.ex_valid = 1'b1; bus.ex_is_branch = br; bus.ex_next_pc = nxt;
    step();
    st = bus.btb_store; pcu = bus.btb_pc_update; nn = bus.btb_next_pc;
    pr = bus.btb_pred_result; rd = bus.redirect; rpc = bus.redirect_pc;
    bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_next_pc = 32'd0;
  endtask

  task automatic wait_ready(output logic ok);
    int n;
    ok = 1'b0; n = 0;
    while (!ok && n < 50) begin
      if (!bus.if_stall) ok = 1'b1;
      else begin step(); n++; end
    end
  endtask

  task automatic test_reset();
    logic [230:0] outs;
    idle_inputs();
    clear_n = 1'b0;
    step(); step();
    outs = {bus.if_stall, bus.if_next_valid, bus.if_next_pc, bus.btb_query, bus.btb_pc_query,
            bus.btb_store, bus.btb_pc_update, bus.btb_next_pc, bus.btb_pred_result,
            bus.redirect, bus.redirect_pc, bus.err_underflow};
    checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", outs); end
    clear_n = 1'b1;
    step();
    checks++; if ({bus.if_stall, bus.btb_query, bus.if_next_valid} !== 3'b000) begin
      errors++; $display("FAIL post_reset_idle got %b exp 000", {bus.if_stall, bus.btb_query, bus.if_next_valid}); end
  endtask

  task automatic test_miss();
    logic q, nv, st, pr, rd; logic [31:0] qpc, npc, pcu, nn, rpc;
    fetch(32'h100, 1'b0, 32'hDEAD_BEEC, q, qpc, nv, npc);
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL miss_query got %b exp 1", q); end
    checks++; if (qpc !== 32'h100) begin errors++; $display("FAIL miss_pc_query got %h exp 100", qpc); end
    checks++; if ({nv, npc} !== {1'b1, 32'h104}) begin errors++; $display("FAIL miss_next got %b/%h exp 1/104", nv, npc); end
    resolve(1'b0, 32'h104, st, pcu, nn, pr, rd, rpc);
    checks++; if ({st, rd} !== 2'b00) begin errors++; $display("FAIL miss_resolve store/redirect got %b exp 00", {st, rd}); end
    fetch(32'hFFFF_FFFC, 1'b0, 32'h0, q, qpc, nv, npc);
    checks++; if ({nv, npc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL pc_wrap got %b/%h exp 1/0", nv, npc); end
    resolve(1'b0, 32'h0, st, pcu, nn, pr, rd, rpc);
    checks++; if ({st, rd} !== 2'b00) begin errors++; $display("FAIL wrap_resolve got %b exp 00", {st, rd}); end
  endtask

  task automatic test_hit();
    logic q, nv, st, pr, rd, ok; logic [31:0] qpc, npc, pcu, nn, rpc;
    fetch(32'h200, 1'b1, 32'h400, q, qpc, nv, npc);
    checks++; if ({nv, npc} !== {1'b1, 32'h400}) begin errors++; $display("FAIL hit_next got %b/%h exp 1/400", nv, npc); end
    resolve(1'b1, 32'h400, st, pcu, nn, pr, rd, rpc);
    checks++; if ({st, pcu, nn, pr, rd} !== {1'b1, 32'h200, 32'h400, 1'b0, 1'b0}) begin
      errors++; $display("FAIL hit_store got %b/%h/%h/%b/%b exp 1/200/400/0/0", st, pcu, nn, pr, rd); end
    fetch(32'h220, 1'b1, 32'h800, q, qpc, nv, npc);
    resolve(1'b0, 32'h224, st, pcu, nn, pr, rd, rpc);
    checks++; if ({st, pcu, pr, rd, rpc} !== {1'b1, 32'h220, 1'b1, 1'b1, 32'h224}) begin
      errors++; $display("FAIL stale_evict got %b/%h/%b/%b/%h exp 1/220/1/1/224", st, pcu, pr, rd, rpc); end
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hit_ready_timeout got %b exp 1", ok); end
  endtask

  task automatic test_mispredict();
    logic q, nv, st, pr, rd, ok; logic [31:0] qpc, npc, pcu, nn, rpc;
    fetch(32'h300, 1'b0, 32'h0, q, qpc, nv, npc);
    fetch(32'h310, 1'b0, 32'h0, q, qpc, nv, npc);
    resolve(1'b1, 32'h500, st, pcu, nn, pr, rd, rpc);
    checks++; if ({st, pcu, nn, pr, rd, rpc} !== {1'b1, 32'h300, 32'h500, 1'b1, 1'b1, 32'h500}) begin
      errors++; $display("FAIL mispred got %b/%h/%h/%b/%b/%h exp 1/300/500/1/1/500", st, pcu, nn, pr, rd, rpc); end
    for (int i = 0; i < FLUSH_CYC; i++) begin
      checks++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL flush_stall cyc %0d got %b exp 1", i, bus.if_stall); end
      step();
    end
    checks++; if ({bus.if_stall, bus.redirect} !== 2'b00) begin errors++; $display("FAIL flush_end got %b exp 00", {bus.if_stall, bus.redirect}); end
    fetch(32'h600, 1'b0, 32'h0, q, qpc, nv, npc);
    resolve(1'b0, 32'h604, st, pcu, nn, pr, rd, rpc);
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL fifo_cleared got redirect %b exp 0", rd); end
    // Mispredict arriving while a lookup is in progress abandons it.
    fetch(32'h700, 1'b0, 32'h0, q, qpc, nv, npc);
    bus.if_valid = 1'b1; bus.if_pc = 32'h710;
    step();
    checks++; if (bus.btb_query !== 1'b1) begin errors++; $display("FAIL abandon_query got %b exp 1", bus.btb_query); end
    bus.if_valid = 1'b0; bus.btb_success = 1'b1; bus.btb_predict = 32'hABC;
    bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_next_pc = 32'h900;
    step();
    checks++; if ({bus.if_next_valid, bus.redirect, bus.redirect_pc} !== {1'b0, 1'b1, 32'h900}) begin
      errors++; $display("FAIL abandon got %b/%b/%h exp 0/1/900", bus.if_next_valid, bus.redirect, bus.redirect_pc); end
    idle_inputs();
    wait_ready(ok);
    fetch(32'h720, 1'b0, 32'h0, q, qpc, nv, npc);
    resolve(1'b0, 32'h724, st, pcu, nn, pr, rd, rpc);
    checks++; if ({ok, rd} !== 2'b10) begin errors++; $display("FAIL abandon_no_push got %b exp 10", {ok, rd}); end
  endtask

  task automatic test_full();
    logic q, nv, st, pr, rd; logic [31:0] qpc, npc, pcu, nn, rpc;
    logic [31:0] drain [4];
    for (int i = 0; i < DEPTH; i++) fetch(32'h1000 + 32'(i) * 32'h10, 1'b0, 32'h0, q, qpc, nv, npc);
    checks++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", bus.if_stall); end
    bus.if_valid = 1'b1; bus.if_pc = 32'h2000;
    step();
    checks++; if (bus.btb_query !== 1'b0) begin errors++; $display("FAIL full_no_query got %b exp 0", bus.btb_query); end
    bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b0; bus.ex_next_pc = 32'h1004;
    step();
    checks++; if ({bus.btb_query, bus.btb_pc_query, bus.redirect} !== {1'b1, 32'h2000, 1'b0}) begin
      errors++; $display("FAIL pop_frees_slot got %b/%h/%b exp 1/2000/0", bus.btb_query, bus.btb_pc_query, bus.redirect); end
    idle_inputs();
    step();
    checks++; if ({bus.if_next_valid, bus.if_next_pc, bus.if_stall} !== {1'b1, 32'h2004, 1'b1}) begin
      errors++; $display("FAIL refill got %b/%h/%b exp 1/2004/1", bus.if_next_valid, bus.if_next_pc, bus.if_stall); end
    resolve(1'b0, 32'h1014, st, pcu, nn, pr, rd, rpc);
    checks++; if ({rd, bus.if_stall} !== 2'b00) begin errors++; $display("FAIL three_left got %b exp 00", {rd, bus.if_stall}); end
    // Push (lookup completion) and pop in the same cycle.
    bus.if_valid = 1'b1; bus.if_pc = 32'h3000;
    step();
    bus.if_valid = 1'b0; bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_next_pc = 32'h1024;
    step();
    checks++; if ({bus.if_next_valid, bus.btb_store, bus.btb_pc_update, bus.redirect} !== {1'b1, 1'b1, 32'h1020, 1'b0}) begin
      errors++; $display("FAIL push_pop got %b/%b/%h/%b exp 1/1/1020/0", bus.if_next_valid, bus.btb_store, bus.btb_pc_update, bus.redirect); end
    idle_inputs();
    checks++; if (bus.if_stall !== 1'b0) begin errors++; $display("FAIL push_pop_count got stall %b exp 0", bus.if_stall); end
    fetch(32'h4000, 1'b0, 32'h0, q, qpc, nv, npc);
    checks++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL count_four got stall %b exp 1", bus.if_stall); end
    drain[0] = 32'h1034; drain[1] = 32'h2004; drain[2] = 32'h3004; drain[3] = 32'h4004;
    for (int i = 0; i < 4; i++) begin
      resolve(1'b0, drain[i], st, pcu, nn, pr, rd, rpc);
      checks++; if (rd !== 1'b0) begin errors++; $display("FAIL drain_%0d redirect got %b exp 0", i, rd); end
    end
    checks++; if (bus.if_stall !== 1'b0) begin errors++; $display("FAIL drained_stall got %b exp 0", bus.if_stall); end
  endtask

  task automatic test_underflow_and_reset();
    logic st, pr, rd; logic [31:0] pcu, nn, rpc;
    resolve(1'b1, 32'h1234, st, pcu, nn, pr, rd, rpc);
    checks++; if ({st, rd, bus.err_underflow} !== 3'b001) begin errors++; $display("FAIL underflow got %b exp 001", {st, rd, bus.err_underflow}); end
    step(); step(); step();
    checks++; if (bus.err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got %b exp 1", bus.err_underflow); end
    bus.if_valid = 1'b1; bus.if_pc = 32'h5000;
    step();
    bus.if_valid = 1'b0; bus.btb_success = 1'b1; bus.btb_predict = 32'h6000;
    clear_n = 1'b0;
    #1;
    checks++; if ({bus.btb_query, bus.btb_pc_query, bus.if_stall, bus.err_underflow} !== '0) begin
      errors++; $display("FAIL midlookup_reset got %b/%h/%b/%b exp 0", bus.btb_query, bus.btb_pc_query, bus.if_stall, bus.err_underflow); end
    step();
    clear_n = 1'b1;
    step();
    checks++; if (bus.if_next_valid !== 1'b0) begin errors++; $display("FAIL reset_no_next got %b exp 0", bus.if_next_valid); end
    idle_inputs();
  endtask

  task automatic test_random();
    model_t      mq[$];
    model_t      e;
    logic        q, nv, st, pr, rd, ok, hit, br, mis;
    logic [31:0] qpc, npc, pcu, nn, rpc, pc, tgt, exp_pc, nxt;
    for (int n = 0; n < 80; n++) begin
      if (mq.size() == DEPTH && ($urandom % 4) == 0) begin
        checks++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL rnd_full_stall got %b exp 1", bus.if_stall); end
        bus.if_valid = 1'b1; bus.if_pc = $urandom;
        step();
        checks++; if (bus.btb_query !== 1'b0) begin errors++; $display("FAIL rnd_full_query got %b exp 0", bus.btb_query); end
        bus.if_valid = 1'b0;
      end else if (mq.size() < DEPTH && (mq.size() == 0 || ($urandom % 2) == 0)) begin
        pc  = (($urandom % 8) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        hit = 1'($urandom % 2);
        tgt = $urandom & 32'hFFFF_FFFC;
        exp_pc = hit ? tgt : pc + 32'd4;
        fetch(pc, hit, tgt, q, qpc, nv, npc);
        checks++; if ({q, qpc} !== {1'b1, pc}) begin errors++; $display("FAIL rnd_query got %b/%h exp 1/%h", q, qpc, pc); end
        checks++; if ({nv, npc} !== {1'b1, exp_pc}) begin errors++; $display("FAIL rnd_next got %b/%h exp 1/%h", nv, npc, exp_pc); end
        mq.push_back('{pc: pc, pred: exp_pc, hit: hit});
      end else begin
        e   = mq.pop_front();
        br  = 1'($urandom % 2);
        mis = (($urandom % 3) == 0);
        nxt = mis ? e.pred + 32'd4 * (32'd1 + 32'($urandom_range(0, 99))) : e.pred;
        resolve(br, nxt, st, pcu, nn, pr, rd, rpc);
        checks++; if (st !== (br | e.hit)) begin errors++; $display("FAIL rnd_store got %b exp %b", st, br | e.hit); end
        if (br | e.hit) begin
          checks++; if ({pcu, nn, pr} !== {e.pc, nxt, mis}) begin
            errors++; $display("FAIL rnd_update got %h/%h/%b exp %h/%h/%b", pcu, nn, pr, e.pc, nxt, mis); end
        end
        checks++; if (rd !== mis) begin errors++; $display("FAIL rnd_redirect got %b exp %b", rd, mis); end
        if (mis) begin
          checks++; if (rpc !== nxt) begin errors++; $display("FAIL rnd_redirect_pc got %h exp %h", rpc, nxt); end
          mq.delete();
          wait_ready(ok);
          checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rnd_ready_timeout got %b exp 1", ok); end
        end
      end
    end
  endtask

`ifdef BPU_STATS_EN
  task automatic test_stats();
    logic q, nv, st, pr, rd; logic [31:0] qpc, npc, pcu, nn, rpc;
    clear_n = 1'b0; idle_inputs(); step(); clear_n = 1'b1; step();
    fetch(32'h100, 1'b1, 32'h900, q, qpc, nv, npc);
    fetch(32'h110, 1'b1, 32'h910, q, qpc, nv, npc);
    fetch(32'h120, 1'b0, 32'h0, q, qpc, nv, npc);
    resolve(1'b1, 32'h990, st, pcu, nn, pr, rd, rpc);
    checks++; if ({bus.stat_lookups, bus.stat_hits, bus.stat_mispred} !== {32'd3, 32'd2, 32'd1}) begin
      errors++; $display("FAIL stats got %0d/%0d/%0d exp 3/2/1", bus.stat_lookups, bus.stat_hits, bus.stat_mispred); end
  endtask
`endif

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_mispredict();
    test_full();
    test_underflow_and_reset();
    test_random();
`ifdef BPU_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
